mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width in bits; legal values are 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port annul_i, input, 1 bit: abort the operation in flight.
REQ-006 SHALL have port op_i, input, 2 bits: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-007 SHALL have port opdata1_i, input, WIDTH bits: multiplicand or dividend.
REQ-008 SHALL have port opdata2_i, input, WIDTH bits: multiplier or divisor.
REQ-009 SHALL have port result_o, output, 2*WIDTH bits.
- mult: {hi, lo} product.
- div: {remainder, quotient}, i.e. upper half is HI, lower half is LO.
REQ-010 SHALL have port ready_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port busy_o, output, 1 bit: operation in flight; drives the pipeline stall request.
REQ-012 SHALL have port div_zero_o, output, 1 bit: the last completed divide had a zero divisor.

Function
REQ-013 SHALL implement the states IDLE, BUSY, ZERO and DONE with these transitions:
- IDLE -> BUSY on start_i.
- IDLE -> ZERO on start_i with a divide op and opdata2_i == 0.
- BUSY -> DONE after the final iteration.
- ZERO -> DONE after one cycle.
- DONE -> IDLE after one cycle.
REQ-014 SHALL capture op_i and both operands on the accepting edge; later input changes have no effect on the operation.
REQ-015 SHALL drive busy_o = 1 in BUSY and ZERO, and 0 in IDLE and DONE.
REQ-016 SHALL drive ready_o = 1 only in DONE, for exactly one cycle per accepted start.
REQ-017 SHALL run the divide as restoring radix-2 over |opdata1| and |opdata2|, one quotient bit per cycle, WIDTH cycles in BUSY.
- ready_o rises WIDTH+1 edges after the accepting edge.
REQ-018 SHALL apply these signed-divide rules:
- quotient sign = sign(opdata1) XOR sign(opdata2).
- remainder sign = sign(opdata1).
- MIN / -1 gives quotient MIN and remainder 0, with no exception.
REQ-019 SHALL, for a zero divisor, produce result_o = 0 and div_zero_o = 1, with ready_o 2 edges after the accepting edge.
REQ-020 SHALL produce a signed or unsigned 2*WIDTH-bit product for multiply, with latency per REQ-030/031.
REQ-021 SHALL hold result_o and div_zero_o stable from DONE until the next accepting edge, so a stalled stage can read them.
REQ-022 SHALL ignore start_i while in BUSY, ZERO or DONE; no queuing.
REQ-023 SHALL, on annul_i = 1 in BUSY or ZERO:
- enter IDLE on the next edge;
- not pulse ready_o;
- leave result_o unchanged.
REQ-024 SHALL ignore annul_i in IDLE and DONE.
REQ-025 SHALL give annul_i priority when annul_i and start_i are high in the same IDLE cycle; the operation is not started.

Reset
REQ-026 SHALL, when rst = 1 at a rising edge, force the state to IDLE and drive result_o = 0, ready_o = 0, busy_o = 0 and div_zero_o = 0.
REQ-027 SHALL abort any in-flight operation on a mid-operation reset, with no ready_o pulse.
REQ-028 SHALL give rst priority over start_i and annul_i.
REQ-029 SHALL accept start_i on the first edge after rst deasserts.

Configuration
REQ-030 SHALL, when macro MUL_DIV_FAST_MUL_EN is defined:
- compute multiply with a single combinational product, registered at the accepting edge;
- go IDLE -> DONE directly, so ready_o rises 1 edge after acceptance.
REQ-031 SHALL, without MUL_DIV_FAST_MUL_EN:
- compute multiply by iterative shift-add over magnitudes, WIDTH cycles in BUSY, then sign-correct;
- raise ready_o WIDTH+1 edges after acceptance, the same as divide.
REQ-032 SHALL leave divide behaviour identical in both configurations.

Verification
REQ-033 SHALL cover, with WIDTH = 32, each of the following scenarios:
- div -7 / 2 (0xFFFFFFF9, 0x00000002) -> ready_o at edge 33; result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quot -3); busy_o high for 32 cycles.
- divu 100 / 0 -> ready_o at edge 2; result_o = 0; div_zero_o = 1; a following divu 100 / 7 gives 0x00000002_0000000E with div_zero_o = 0.
- mult 0xFFFFFFFF x 2 -> 0xFFFFFFFF_FFFFFFFE; multu with the same operands -> 0x00000001_FFFFFFFE; latency 1 edge with MUL_DIV_FAST_MUL_EN and 33 edges without.
- div 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
- start divu, annul_i at edge 10 -> no ready_o pulse, IDLE at edge 11, result_o unchanged; a new start completes normally.
- start div, second start_i with other operands at edge 5, rst at edge 20 -> second start ignored, all outputs 0 after edge 20, no ready_o pulse.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit (signed and unsigned).
// Divide: restoring radix-2 over operand magnitudes, one quotient bit per cycle.
// Multiply: iterative shift-add by default. Defining MUL_DIV_FAST_MUL_EN replaces it
// with a single-cycle combinational product.
// result_o and div_zero_o are written only on entry to DONE, or at acceptance for a
// fast multiply. An annulled or reset operation therefore never disturbs them.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

`ifdef MUL_DIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ZERO = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic               div_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   m_q;
    logic [CW-1:0]      cnt_q;

    logic               is_div_c;
    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [2*WIDTH-1:0] ext1_c;
    logic [2*WIDTH-1:0] ext2_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH:0]     msum_c;
    logic [WIDTH:0]     trial_c;
    logic [WIDTH-1:0]   step_hi_c;
    logic [WIDTH-1:0]   step_lo_c;
    logic [2*WIDTH-1:0] mag_c;
    logic [2*WIDTH-1:0] mul_fin_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;
    logic [2*WIDTH-1:0] final_c;

    // Operand decode: op_i[1] selects divide, op_i[0] selects unsigned
    always_comb begin
        is_div_c = op_i[1];
        a_neg_c  = ~op_i[0] & opdata1_i[WIDTH-1];
        b_neg_c  = ~op_i[0] & opdata2_i[WIDTH-1];
        a_mag_c  = a_neg_c ? (WIDTH'(0) - opdata1_i) : opdata1_i;
        b_mag_c  = b_neg_c ? (WIDTH'(0) - opdata2_i) : opdata2_i;
        ext1_c   = op_i[0] ? {WIDTH'(0), opdata1_i} : {{WIDTH{opdata1_i[WIDTH-1]}}, opdata1_i};
        ext2_c   = op_i[0] ? {WIDTH'(0), opdata2_i} : {{WIDTH{opdata2_i[WIDTH-1]}}, opdata2_i};
        prod_c   = ext1_c * ext2_c;
    end

    // One iteration of shift-add multiply or restoring divide, plus the sign fix-up
    always_comb begin
        msum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : (WIDTH + 1)'(0));
        trial_c = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
        if (div_q) begin
            if (!trial_c[WIDTH]) begin
                step_hi_c = trial_c[WIDTH-1:0];
                step_lo_c = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_c = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                step_lo_c = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_c = msum_c[WIDTH:1];
            step_lo_c = {msum_c[0], lo_q[WIDTH-1:1]};
        end
        mag_c     = {step_hi_c, step_lo_c};
        mul_fin_c = neg_q ? ((2 * WIDTH)'(0) - mag_c) : mag_c;
        quo_c     = neg_q ? (WIDTH'(0) - step_lo_c) : step_lo_c;
        rem_c     = rem_neg_q ? (WIDTH'(0) - step_hi_c) : step_hi_c;
        final_c   = div_q ? {rem_c, quo_c} : mul_fin_c;
    end

    // Next-state logic; annul wins over start in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    if (is_div_c && (opdata2_i == WIDTH'(0))) begin
                        state_d = S_ZERO;
                    end else if (FAST_MUL && !is_div_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_ZERO:  state_d = annul_i ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered status outputs, operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o     <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
            div_q      <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
        end else begin
            busy_o  <= (state_d == S_BUSY) || (state_d == S_ZERO);
            ready_o <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        div_q     <= is_div_c;
                        neg_q     <= a_neg_c ^ b_neg_c;
                        rem_neg_q <= a_neg_c;
                        hi_q      <= '0;
                        lo_q      <= is_div_c ? a_mag_c : b_mag_c;
                        m_q       <= is_div_c ? b_mag_c : a_mag_c;
                        cnt_q     <= '0;
                        if (FAST_MUL && !is_div_c) begin
                            result_o   <= prod_c;
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    if (!annul_i) begin
                        hi_q  <= step_hi_c;
                        lo_q  <= step_lo_c;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            result_o   <= final_c;
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                S_ZERO: begin
                    if (!annul_i) begin
                        result_o   <= '0;
                        div_zero_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit at WIDTH = 32.
// It follows MUL_DIV_FAST_MUL_EN for the expected multiply latency.
// Edge 1 is the accepting edge. Latency is the edge number at which ready_o is seen.
module tb_mul_div_unit;
    localparam int W  = 32;
    localparam int DL = W + 1;
`ifdef MUL_DIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = W + 1;
`endif
    localparam int NV = 15;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [63:0]  res;
        logic         dz;
        int           lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          annul_i;
    logic [1:0]    op_i;
    logic [W-1:0]  opdata1_i;
    logic [W-1:0]  opdata2_i;
    logic [63:0]   result_o;
    logic          ready_o;
    logic          busy_o;
    logic          div_zero_o;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, wait for ready_o (bounded)
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n);
        @(negedge clk);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = ~op; opdata1_i = $urandom; opdata2_i = $urandom;
        lat = 1;
        busy_n = 0;
        while (ready_o !== 1'b1 && lat < 100) begin
            if (busy_o === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          vt [NV];
        int            lat;
        int            bn;
        int            rdy_n;
        logic [63:0]   prev_res;
        logic          prev_dz;

        vt[0]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, DL};
        vt[1]  = '{2'b11, 32'd100,      32'h00000000, 64'h00000000_00000000, 1'b1, 2};
        vt[2]  = '{2'b11, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, DL};
        vt[3]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 1'b0, ML};
        vt[4]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, 1'b0, ML};
        vt[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, DL};
        vt[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, DL};
        vt[7]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0, DL};
        vt[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 1'b0, DL};
        vt[9]  = '{2'b10, 32'h00000000, 32'h00000000, 64'h00000000_00000000, 1'b1, 2};
        vt[10] = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, ML};
        vt[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, ML};
        vt[12] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 1'b0, ML};
        vt[13] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1'b0, DL};
        vt[14] = '{2'b10, 32'h00000005, 32'h00000007, 64'h00000005_00000000, 1'b0, DL};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 64'h0);
        check("reset ready", 64'(ready_o), 64'h0);
        check("reset busy", 64'(busy_o), 64'h0);
        check("reset div_zero", 64'(div_zero_o), 64'h0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, lat, bn);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("v%0d busy_cycles", i), 64'(bn), 64'(vt[i].lat - 1));
            check($sformatf("v%0d result", i), result_o, vt[i].res);
            check($sformatf("v%0d div_zero", i), 64'(div_zero_o), 64'(vt[i].dz));
            @(posedge clk); #1;
            check($sformatf("v%0d ready_single", i), 64'(ready_o), 64'h0);
            check($sformatf("v%0d result_hold", i), result_o, vt[i].res);
        end

        // Annul a divu at edge 10
        prev_res = result_o;
        prev_dz  = div_zero_o;
        rdy_n = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd100; opdata2_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            rdy_n += int'(ready_o);
        end
        check("annul busy_before", 64'(busy_o), 64'h1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul busy_after", 64'(busy_o), 64'h0);
        check("annul result_kept", result_o, prev_res);
        check("annul div_zero_kept", 64'(div_zero_o), 64'(prev_dz));
        repeat (40) begin
            @(posedge clk); #1;
            rdy_n += int'(ready_o);
        end
        check("annul no_ready", 64'(rdy_n), 64'h0);
        run_op(2'b11, 32'd1000, 32'd3, lat, bn);
        check("post_annul latency", 64'(lat), 64'(DL));
        check("post_annul result", result_o, 64'h00000001_0000014D);

        // Annul and start together in IDLE: start is dropped
        rdy_n = 0;
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd9; opdata2_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_start busy", 64'(busy_o), 64'h0);
        repeat (40) begin
            @(posedge clk); #1;
            rdy_n += int'(ready_o);
        end
        check("annul_start no_ready", 64'(rdy_n), 64'h0);
        check("annul_start result", result_o, 64'h00000001_0000014D);

        // Annul during ZERO
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd5; opdata2_i = 32'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("zero busy", 64'(busy_o), 64'h1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("zero_annul busy", 64'(busy_o), 64'h0);
        check("zero_annul ready", 64'(ready_o), 64'h0);
        check("zero_annul div_zero", 64'(div_zero_o), 64'h0);
        check("zero_annul result", result_o, 64'h00000001_0000014D);

        // Second start ignored while busy, reset at edge 20 aborts the divide
        rdy_n = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'hFFFFFFF9; opdata2_i = 32'h2;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            rdy_n += int'(ready_o);
        end
        start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd100; opdata2_i = 32'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("second_start busy", 64'(busy_o), 64'h1);
        check("second_start div_zero", 64'(div_zero_o), 64'h0);
        repeat (14) begin
            @(posedge clk); #1;
            rdy_n += int'(ready_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset result", result_o, 64'h0);
        check("midreset ready", 64'(ready_o), 64'h0);
        check("midreset busy", 64'(busy_o), 64'h0);
        check("midreset div_zero", 64'(div_zero_o), 64'h0);
        check("midreset no_ready", 64'(rdy_n), 64'h0);
        run_op(2'b01, 32'hFFFFFFFF, 32'h2, lat, bn);
        check("post_reset latency", 64'(lat), 64'(ML));
        check("post_reset result", result_o, 64'h00000001_FFFFFFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
